// File: rtl/keccak_squeeze_stream.sv
// keccak_squeeze_stream: lane-serial squeeze engine for the Keccak sponge.
// A permuted 1600-bit state is captured whole, then the first `rate` lanes
// are streamed out as 64-bit words over valid/ready. When the rate is used
// up before the requested word count is reached, a fresh permuted state is
// requested from the permutation core and streaming resumes at lane 0.
module keccak_squeeze_stream #(
    parameter int LANE_W    = 64,
    parameter int NUM_LANES = 25
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4:0]                  rate_lanes,
    input  logic [15:0]                 num_words,
    input  logic [LANE_W*NUM_LANES-1:0] state_in,
    input  logic                        load_valid,
    output logic                        load_ready,
    output logic                        need_state,
    output logic [LANE_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    // Largest legal rate (SHAKE128); also the fallback for illegal requests.
    localparam logic [4:0] MAX_RATE = 5'd21;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STATE = 2'd1,
        STREAM     = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [4:0]        rate_reg, rate_next;
    logic [4:0]        lane_idx_reg, lane_idx_next;
    logic [15:0]       remaining_reg, remaining_next;
    logic              done_reg, done_next;
    logic              load_en;
    logic [4:0]        rate_eff;
    logic [LANE_W-1:0] lane_in  [NUM_LANES];
    logic [LANE_W-1:0] lane_reg [NUM_LANES];

    // Illegal rates (0 or above the SHAKE128 rate) are clamped to 21 lanes.
    assign rate_eff = ((rate_lanes == 5'd0) || (rate_lanes > MAX_RATE)) ? MAX_RATE : rate_lanes;

    // Slice the packed state into lanes; lane i lives at bits [i*LANE_W +: LANE_W].
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_slice
            assign lane_in[gi] = state_in[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Next-state logic and handshake outputs of the squeeze controller.
    always_comb begin
        state_next     = state_reg;
        rate_next      = rate_reg;
        lane_idx_next  = lane_idx_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        load_en        = 1'b0;
        load_ready     = 1'b0;
        need_state     = 1'b0;
        out_valid      = 1'b0;
        out_last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (num_words != 16'd0) begin
                        rate_next      = rate_eff;
                        remaining_next = num_words;
                        lane_idx_next  = 5'd0;
                        state_next     = WAIT_STATE;
                    end else begin
                        // Empty request completes immediately without touching the core.
                        done_next = 1'b1;
                    end
                end
            end
            WAIT_STATE: begin
                load_ready = 1'b1;
                need_state = 1'b1;
                if (load_valid) begin
                    load_en       = 1'b1;
                    lane_idx_next = 5'd0;
                    state_next    = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (remaining_reg == 16'd1);
                if (out_ready) begin
                    // remaining is at least 1 here, so the decrement cannot wrap.
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (lane_idx_reg == (rate_reg - 5'd1)) begin
                        // Rate exhausted: capacity lanes are never emitted.
                        lane_idx_next = 5'd0;
                        state_next    = WAIT_STATE;
                    end else begin
                        lane_idx_next = lane_idx_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller registers: FSM state, captured parameters and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rate_reg      <= 5'd0;
            lane_idx_reg  <= 5'd0;
            remaining_reg <= 16'd0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rate_reg      <= rate_next;
            lane_idx_reg  <= lane_idx_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
        end
    end

    // Lane register: the whole permuted state is captured on the load handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_reg[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_reg[i] <= lane_in[i];
            end
        end
    end

    // Output word comes straight from the lane registers, never from state_in.
    assign out_data = lane_reg[lane_idx_reg];
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: doc/keccak_squeeze_stream.md
# keccak_squeeze_stream

- Lane-serial squeeze engine for the Keccak sponge in the Kyber768 datapath.
- Takes a permuted 1600-bit state from the permutation core.
- Emits the first `rate_lanes` lanes as a stream of 64-bit words over a valid/ready handshake.
- Requests a fresh permuted state each time the rate is exhausted, until the requested word count has been delivered.
- Feeds SHAKE128/SHAKE256 output to the sampler and CBD blocks.

## Interface
Parameters:
- `LANE_W`, 64: lane width in bits.
- `NUM_LANES`, 25: lanes in the state; the state is `LANE_W*NUM_LANES` = 1600 bits.

Ports (reset is synchronous and active-low):
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `start` input 1: one-cycle request to begin a squeeze; sampled only in IDLE.
- `rate_lanes` input 5: rate in lanes (21 = SHAKE128, 17 = SHAKE256); captured on `start`.
- `num_words` input 16: total 64-bit words to emit; captured on `start`.
- `state_in` input 1600: packed permuted state; lane i at bits `[i*64 +: 64]`.
- `load_valid` input 1: `state_in` is valid.
- `load_ready` output 1: block accepts a state this cycle.
- `need_state` output 1: block is waiting for a (re)permuted state; drives the permutation core's go.
- `out_data` output 64: current lane word.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts `out_data`.
- `out_last` output 1: current word is the final word of the squeeze.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when the squeeze completes.

## Operation
State machine with three states: IDLE, WAIT_STATE, STREAM.

IDLE:
- `start` with `num_words != 0`:
  - Capture `rate_lanes`; values of 0 or greater than 21 are replaced by 21.
  - Set `remaining = num_words` and `lane_idx = 0`.
  - Go to WAIT_STATE.
- `start` with `num_words == 0`: pulse `done` next cycle and stay in IDLE.

WAIT_STATE:
- `need_state` = 1 and `load_ready` = 1.
- On `load_valid && load_ready`: register all 25 lanes, set `lane_idx = 0`, go to STREAM.

STREAM:
- Outputs:
  - `out_valid` = 1.
  - `out_data` = registered lane[`lane_idx`].
  - `out_last` = (`remaining == 1`).
- On handshake (`out_valid && out_ready`), `remaining` decrements and one of:
  - If `remaining == 1` → IDLE; pulse `done` in the next cycle.
  - Else if `lane_idx == rate - 1` → WAIT_STATE with `lane_idx = 0` (wrap-around; the remaining rate is exhausted).
  - Else `lane_idx += 1`.
- No handshake: hold `out_data`, `out_valid`, `lane_idx` and `remaining` stable.

Other rules:
- Capacity lanes (index ≥ rate) are never emitted.
- `start` is ignored whenever `busy` = 1.
- `load_valid` is ignored outside WAIT_STATE; `load_ready` = 0 there.
- `remaining` is 16-bit unsigned and never underflows; the last-word check precedes the decrement.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and the lane register clears.
- Reset mid-operation:
  - `out_valid`, `need_state` and `busy` are 0 the cycle after `rst_n` is sampled low.
  - No `done` pulse is generated.
  - Captured parameters are discarded.
- Latency:
  - `start` in cycle N → `need_state`/`load_ready` high in N+1.
  - Load handshake in cycle M → `out_valid` with lane 0 in M+1.
- Throughput: one word per cycle while `out_ready` = 1.
- Rate wrap costs a minimum of one bubble cycle, since the next load handshake can occur at the earliest the cycle after the wrap.
- `done` is high exactly one cycle, the cycle after the final handshake; `busy` falls in the same cycle.
- `out_data` is driven from registers (no combinational path from `state_in`).

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with random inputs → all outputs 0, `busy` = 0.
- **Single block, no wrap:**
  - Stimulus: `rate_lanes` = 21, `num_words` = 5; lane i = `{32'hA5A5A5A5, 32'(i)}`; `out_ready` tied 1.
  - Required response:
    - Words `A5A5A5A5_00000000` through `..._00000004`, on consecutive cycles.
    - `out_last` on the 5th word.
    - `done` one cycle later; `need_state` pulses exactly once.
- **Rate wrap:**
  - Stimulus: `rate_lanes` = 17, `num_words` = 20.
  - Required response:
    - Lanes 0..16 of state A.
    - Return to WAIT_STATE with `out_valid` = 0 until state B is loaded.
    - Then lanes 0..2 of B, with `out_last` on B lane 2.
- **Backpressure:**
  - Stimulus: toggle `out_ready` 1,0,0,1,… during SHAKE128, `num_words` = 4.
  - Required response: `out_data` stable while stalled; no word skipped or duplicated; exactly 4 handshakes.
- **Edge inputs:**
  - `start` with `num_words` = 0 → `done` next cycle, no `need_state`.
  - `rate_lanes` = 0 → behaves as 21; lane 21 (index ≥ 21) is never emitted.
- **Reset mid-stream and ignored inputs:**
  - `start` asserted during STREAM → ignored.
  - `rst_n` low after 3 words of a 10-word squeeze → IDLE, no `done`.
  - A fresh squeeze after reset starts at lane 0.
